id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register plus operand-forwarding network, directly upstream of the EX-stage ALU.
- Captures decoded fields from ID and drives the ALU's operand1, operand2, mode and en.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards: stalls ID and inserts a bubble.

---
 rtl/id_ex_operand_stage.sv | 169 ++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
//   ID/EX pipeline register with an operand-forwarding network that feeds the
//   EX-stage ALU. Also detects load-use hazards: it stalls ID and inserts a
//   bubble into EX, and keeps a saturating count of the bubbles it inserts.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   id_*                decoded instruction fields presented by ID
//   flush               squash the instruction entering EX (taken branch)
//   hold                downstream freeze; every register keeps its value
//   exm_*, mwb_*        EX/MEM and MEM/WB writeback info used for forwarding
//   stall_id            freeze IF/ID this cycle (combinational)
//   alu_operand1/2,
//   alu_mode, alu_en    ALU drive; alu_en mirrors ex_valid
//   ex_valid            EX holds a real instruction
//   ex_rd_idx           registered destination index
//   ex_reg_write        registered reg_write qualified by ex_valid
//   ex_mem_read         registered mem_read qualified by ex_valid
//   ex_store_data       forwarded rt value for stores
//   bubble_count        saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module id_ex_operand_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_val,
    input  logic [DATA_W-1:0] id_rt_val,
    input  logic [REG_AW-1:0] id_rs_idx,
    input  logic [REG_AW-1:0] id_rt_idx,
    input  logic [REG_AW-1:0] id_rd_idx,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_alu_src_imm,
    input  logic [3:0]        id_alu_mode,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    input  logic              hold,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd_idx,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_reg_write,
    input  logic [REG_AW-1:0] mwb_rd_idx,
    input  logic [DATA_W-1:0] mwb_result,
    output logic              stall_id,
    output logic [DATA_W-1:0] alu_operand1,
    output logic [DATA_W-1:0] alu_operand2,
    output logic [3:0]        alu_mode,
    output logic              alu_en,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rd_idx,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [CNT_W-1:0]  bubble_count
);

    logic              valid_q;
    logic [DATA_W-1:0] rs_val_q;
    logic [DATA_W-1:0] rt_val_q;
    logic [REG_AW-1:0] rs_idx_q;
    logic [REG_AW-1:0] rt_idx_q;
    logic [REG_AW-1:0] rd_idx_q;
    logic [DATA_W-1:0] imm_q;
    logic              src_imm_q;
    logic [3:0]        mode_q;
    logic              reg_write_q;
    logic              mem_read_q;
    logic [CNT_W-1:0]  bubble_q;
    logic [CNT_W-1:0]  bubble_d;

    logic              lu;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // Load-use: the load in EX produces its data too late for the consumer in ID.
    always_comb begin
        lu = valid_q && mem_read_q && id_valid &&
             ((id_rs_used && (id_rs_idx == rd_idx_q)) ||
              (id_rt_used && (id_rt_idx == rd_idx_q)));
    end

    always_comb begin
        stall_id = (lu && !flush) || hold;
    end

    always_comb begin
        bubble_d = bubble_q;
        if (bubble_q != '1) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    // Priority: flush > hold > load-use bubble > normal capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rs_val_q    <= '0;
            rt_val_q    <= '0;
            rs_idx_q    <= '0;
            rt_idx_q    <= '0;
            rd_idx_q    <= '0;
            imm_q       <= '0;
            src_imm_q   <= 1'b0;
            mode_q      <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            bubble_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (hold) begin
            valid_q <= valid_q;
        end else if (lu) begin
            valid_q  <= 1'b0;
            bubble_q <= bubble_d;
        end else begin
            valid_q     <= id_valid;
            rs_val_q    <= id_rs_val;
            rt_val_q    <= id_rt_val;
            rs_idx_q    <= id_rs_idx;
            rt_idx_q    <= id_rt_idx;
            rd_idx_q    <= id_rd_idx;
            imm_q       <= id_imm;
            src_imm_q   <= id_alu_src_imm;
            mode_q      <= id_alu_mode;
            reg_write_q <= id_reg_write;
            mem_read_q  <= id_mem_read;
        end
    end

    // Forwarding: EX/MEM is the younger producer, so it beats MEM/WB.
    always_comb begin
        fwd_rs = rs_val_q;
        if (exm_reg_write && (exm_rd_idx == rs_idx_q)) begin
            fwd_rs = exm_result;
        end else if (mwb_reg_write && (mwb_rd_idx == rs_idx_q)) begin
            fwd_rs = mwb_result;
        end
    end

    always_comb begin
        fwd_rt = rt_val_q;
        if (exm_reg_write && (exm_rd_idx == rt_idx_q)) begin
            fwd_rt = exm_result;
        end else if (mwb_reg_write && (mwb_rd_idx == rt_idx_q)) begin
            fwd_rt = mwb_result;
        end
    end

    always_comb begin
        alu_operand1  = fwd_rs;
        alu_operand2  = src_imm_q ? imm_q : fwd_rt;
        ex_store_data = fwd_rt;
        alu_mode      = mode_q;
        alu_en        = valid_q;
        ex_valid      = valid_q;
        ex_rd_idx     = rd_idx_q;
        ex_reg_write  = reg_write_q && valid_q;
        ex_mem_read   = mem_read_q && valid_q;
        bubble_count  = bubble_q;
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_rs_val, id_rt_val, id_imm;
    logic [4:0]  id_rs_idx, id_rt_idx, id_rd_idx;
    logic        id_rs_used, id_rt_used, id_alu_src_imm, id_reg_write, id_mem_read;
    logic [3:0]  id_alu_mode;
    logic        flush, hold;
    logic        exm_reg_write, mwb_reg_write;
    logic [4:0]  exm_rd_idx, mwb_rd_idx;
    logic [31:0] exm_result, mwb_result;

    logic        stall_id, alu_en, ex_valid, ex_reg_write, ex_mem_read;
    logic [31:0] alu_operand1, alu_operand2, ex_store_data;
    logic [3:0]  alu_mode;
    logic [4:0]  ex_rd_idx;
    logic [15:0] bubble_count;

    // Second instance with a 2-bit counter to reach saturation quickly.
    logic        s_stall_id, s_alu_en, s_ex_valid, s_ex_reg_write, s_ex_mem_read;
    logic [31:0] s_alu_operand1, s_alu_operand2, s_ex_store_data;
    logic [3:0]  s_alu_mode;
    logic [4:0]  s_ex_rd_idx;
    logic [1:0]  s_bubble_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
        .id_rs_idx(id_rs_idx), .id_rt_idx(id_rt_idx), .id_rd_idx(id_rd_idx),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_imm(id_imm),
        .id_alu_src_imm(id_alu_src_imm), .id_alu_mode(id_alu_mode),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .hold(hold),
        .exm_reg_write(exm_reg_write), .exm_rd_idx(exm_rd_idx), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd_idx(mwb_rd_idx), .mwb_result(mwb_result),
        .stall_id(stall_id), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .alu_mode(alu_mode), .alu_en(alu_en), .ex_valid(ex_valid),
        .ex_rd_idx(ex_rd_idx), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_store_data(ex_store_data), .bubble_count(bubble_count)
    );

    id_ex_operand_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
        .id_rs_idx(id_rs_idx), .id_rt_idx(id_rt_idx), .id_rd_idx(id_rd_idx),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_imm(id_imm),
        .id_alu_src_imm(id_alu_src_imm), .id_alu_mode(id_alu_mode),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .hold(hold),
        .exm_reg_write(exm_reg_write), .exm_rd_idx(exm_rd_idx), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd_idx(mwb_rd_idx), .mwb_result(mwb_result),
        .stall_id(s_stall_id), .alu_operand1(s_alu_operand1), .alu_operand2(s_alu_operand2),
        .alu_mode(s_alu_mode), .alu_en(s_alu_en), .ex_valid(s_ex_valid),
        .ex_rd_idx(s_ex_rd_idx), .ex_reg_write(s_ex_reg_write), .ex_mem_read(s_ex_mem_read),
        .ex_store_data(s_ex_store_data), .bubble_count(s_bubble_count)
    );

    typedef struct {
        string       tag;
        logic        chk_ops;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] store;
        logic [3:0]  mode;
        logic        en;
        logic [15:0] bc;
        logic [1:0]  bcs;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic chk_ops,
                                input logic [31:0] op1, input logic [31:0] op2,
                                input logic [31:0] store, input logic [3:0] mode,
                                input logic en, input logic [15:0] bc);
        exp_t e;
        e.tag = tag; e.chk_ops = chk_ops; e.op1 = op1; e.op2 = op2;
        e.store = store; e.mode = mode; e.en = en; e.bc = bc;
        e.bcs = (bc > 16'd3) ? 2'd3 : bc[1:0];
        return e;
    endfunction

    // Push the expectation for the state after the coming edge, then pop and compare.
    task automatic expect_step(input exp_t e);
        exp_t g;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            g = sbq.pop_front();
            chk({g.tag, "/en"}, {63'd0, alu_en}, {63'd0, g.en});
            chk({g.tag, "/valid"}, {63'd0, ex_valid}, {63'd0, g.en});
            chk({g.tag, "/bc"}, {48'd0, bubble_count}, {48'd0, g.bc});
            chk({g.tag, "/bc_sat"}, {62'd0, s_bubble_count}, {62'd0, g.bcs});
            if (g.chk_ops) begin
                chk({g.tag, "/op1"}, {32'd0, alu_operand1}, {32'd0, g.op1});
                chk({g.tag, "/op2"}, {32'd0, alu_operand2}, {32'd0, g.op2});
                chk({g.tag, "/store"}, {32'd0, ex_store_data}, {32'd0, g.store});
                chk({g.tag, "/mode"}, {60'd0, alu_mode}, {60'd0, g.mode});
            end
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rsi, input logic [31:0] rsv,
                          input logic [4:0] rti, input logic [31:0] rtv,
                          input logic rsu, input logic rtu, input logic [4:0] rd,
                          input logic [31:0] imm, input logic src, input logic [3:0] mode,
                          input logic rw, input logic mr);
        id_valid = v; id_rs_idx = rsi; id_rs_val = rsv; id_rt_idx = rti; id_rt_val = rtv;
        id_rs_used = rsu; id_rt_used = rtu; id_rd_idx = rd; id_imm = imm;
        id_alu_src_imm = src; id_alu_mode = mode; id_reg_write = rw; id_mem_read = mr;
    endtask

    initial begin
        rst_n = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0);
        flush = 0; hold = 0;
        exm_reg_write = 0; exm_rd_idx = 0; exm_result = 0;
        mwb_reg_write = 0; mwb_rd_idx = 0; mwb_result = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst/en", {63'd0, alu_en}, 64'd0);
        chk("rst/bc", {48'd0, bubble_count}, 64'd0);
        chk("rst/mode", {60'd0, alu_mode}, 64'd0);
        chk("rst/regw", {63'd0, ex_reg_write}, 64'd0);
        chk("rst/stall", {63'd0, stall_id}, 64'd0);
        rst_n = 1'b1;

        // Plain issue, no forwarding.
        @(negedge clk);
        set_id(1, 5'd1, 32'd5, 5'd2, 32'd7, 1, 1, 5'd10, 32'd0, 0, 4'b0000, 1, 0);
        expect_step(mk("plain", 1, 32'd5, 32'd7, 32'd7, 4'b0000, 1, 16'd0));
        chk("plain/rd", {59'd0, ex_rd_idx}, 64'd10);
        chk("plain/regw", {63'd0, ex_reg_write}, 64'd1);
        chk("plain/memr", {63'd0, ex_mem_read}, 64'd0);

        // Both later stages write r3: EX/MEM wins, then MEM/WB, then regfile value.
        @(negedge clk);
        set_id(1, 5'd3, 32'h55, 5'd2, 32'd7, 1, 1, 5'd11, 32'd0, 0, 4'b0011, 1, 0);
        exm_reg_write = 1; exm_rd_idx = 5'd3; exm_result = 32'h11;
        mwb_reg_write = 1; mwb_rd_idx = 5'd3; mwb_result = 32'h22;
        expect_step(mk("dfwd", 1, 32'h11, 32'd7, 32'd7, 4'b0011, 1, 16'd0));
        exm_reg_write = 0;
        #1 chk("dfwd/mwb", {32'd0, alu_operand1}, 64'h22);
        mwb_reg_write = 0;
        #1 chk("dfwd/none", {32'd0, alu_operand1}, 64'h55);

        // Immediate select while rt is forwarded from EX/MEM.
        @(negedge clk);
        set_id(1, 5'd1, 32'd1, 5'd6, 32'hdead, 1, 1, 5'd12, 32'hFFFF_FFFC, 1, 4'b0101, 1, 0);
        exm_reg_write = 1; exm_rd_idx = 5'd6; exm_result = 32'd9;
        expect_step(mk("imm", 1, 32'd1, 32'hFFFF_FFFC, 32'd9, 4'b0101, 1, 16'd0));
        exm_reg_write = 0;

        // Load-use: lw r4 in EX, consumer reads r4.
        @(negedge clk);
        set_id(1, 5'd1, 32'h100, 5'd0, 32'd0, 1, 0, 5'd4, 32'd8, 1, 4'b0000, 1, 1);
        expect_step(mk("lw", 1, 32'h100, 32'd8, 32'd0, 4'b0000, 1, 16'd0));
        chk("lw/memr", {63'd0, ex_mem_read}, 64'd1);
        @(negedge clk);
        set_id(1, 5'd4, 32'h77, 5'd2, 32'd3, 1, 1, 5'd5, 32'd0, 0, 4'b0001, 1, 0);
        #1 chk("lu/stall", {63'd0, stall_id}, 64'd1);
        expect_step(mk("lu_bubble", 1, 32'h100, 32'd8, 32'd0, 4'b0000, 0, 16'd1));
        chk("lu/stall_clear", {63'd0, stall_id}, 64'd0);
        chk("lu/memr_gated", {63'd0, ex_mem_read}, 64'd0);
        @(negedge clk);
        mwb_reg_write = 1; mwb_rd_idx = 5'd4; mwb_result = 32'hABC;
        expect_step(mk("lu_after", 1, 32'hABC, 32'd3, 32'd3, 4'b0001, 1, 16'd1));
        mwb_reg_write = 0;

        // Flush together with a load-use hazard.
        @(negedge clk);
        set_id(1, 5'd1, 32'h200, 5'd0, 32'd0, 1, 0, 5'd4, 32'd8, 1, 4'b0000, 1, 1);
        expect_step(mk("lw2", 1, 32'h200, 32'd8, 32'd0, 4'b0000, 1, 16'd1));
        @(negedge clk);
        set_id(1, 5'd4, 32'h77, 5'd2, 32'd3, 1, 1, 5'd5, 32'd0, 0, 4'b0001, 1, 0);
        flush = 1;
        #1 chk("flush/stall", {63'd0, stall_id}, 64'd0);
        expect_step(mk("flush", 0, 32'd0, 32'd0, 32'd0, 4'd0, 0, 16'd1));
        flush = 0;

        // Hold together with a load-use hazard: frozen, then the bubble lands.
        @(negedge clk);
        set_id(1, 5'd1, 32'h300, 5'd0, 32'd0, 1, 0, 5'd4, 32'd8, 1, 4'b0010, 1, 1);
        expect_step(mk("lw3", 1, 32'h300, 32'd8, 32'd0, 4'b0010, 1, 16'd1));
        @(negedge clk);
        set_id(1, 5'd4, 32'h77, 5'd2, 32'd3, 1, 1, 5'd5, 32'd0, 0, 4'b0001, 1, 0);
        hold = 1;
        #1 chk("hold/stall", {63'd0, stall_id}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            expect_step(mk("hold", 1, 32'h300, 32'd8, 32'd0, 4'b0010, 1, 16'd1));
        end
        @(negedge clk);
        hold = 0;
        #1 chk("unhold/stall", {63'd0, stall_id}, 64'd1);
        expect_step(mk("hold_lu", 1, 32'h300, 32'd8, 32'd0, 4'b0010, 0, 16'd2));
        expect_step(mk("hold_after", 1, 32'h77, 32'd3, 32'd3, 4'b0001, 1, 16'd2));

        // More bubbles; the 2-bit counter must stop at 3.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_id(1, 5'd1, 32'h100, 5'd0, 32'd0, 1, 0, 5'd4, 32'd8, 1, 4'b0000, 1, 1);
            expect_step(mk("sat_lw", 1, 32'h100, 32'd8, 32'd0, 4'b0000, 1, 16'(2 + i)));
            @(negedge clk);
            set_id(1, 5'd4, 32'h77, 5'd2, 32'd3, 1, 1, 5'd5, 32'd0, 0, 4'b0001, 1, 0);
            expect_step(mk("sat_bub", 1, 32'h100, 32'd8, 32'd0, 4'b0000, 0, 16'(3 + i)));
        end

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst/valid", {63'd0, ex_valid}, 64'd0);
        chk("arst/en", {63'd0, alu_en}, 64'd0);
        chk("arst/bc", {48'd0, bubble_count}, 64'd0);
        chk("arst/bc_sat", {62'd0, s_bubble_count}, 64'd0);
        chk("arst/mode", {60'd0, alu_mode}, 64'd0);
        chk("arst/stall", {63'd0, stall_id}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
